ql_membank_cfg_ctrl: RTL and testbench
======================================

# ql_membank_cfg_ctrl

Configuration controller for the QL memory-bank FPGA fabric. It accepts a bitstream as a valid/ready word stream and assembles one BL frame per word line. It writes each frame by pulsing the matching WL row, then releases `global_resetn` to the fabric once every row is written. It sits between the bitstream source (host bridge or boot ROM streamer) and the fabric's `bl_config_region_0` / `wl_config_region_0` / `global_resetn` ports, and replaces the testbench-only bitstream forcing.

## Interface
- `BL_WIDTH`, 514: bits per BL frame (fabric `bl_config_region_0` width)
- `WL_ROWS`, 407: number of word-line rows (fabric `wl_config_region_0` width)
- `DATA_W`, 32: input stream word width
- `WL_PULSE`, 2: cycles each WL row is held high (≥1)
- `RST_DELAY`, 10: cycles between the last row write and `global_resetn` rising (≥1)

Ports:
- `clk` in 1: single clock; all logic on its rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: single-cycle request to begin configuration
- `cfg_data` in DATA_W: bitstream word
- `cfg_valid` in 1: `cfg_data` valid
- `cfg_ready` out 1: controller accepts the word this cycle
- `bl` out BL_WIDTH: to fabric bit lines
- `wl` out WL_ROWS: to fabric word lines, one-hot or zero
- `global_resetn` out 1: fabric reset, low while unconfigured
- `cfg_busy` out 1: configuration in progress
- `cfg_done` out 1: fabric configured and released
- `cfg_error` out 1: CRC mismatch (0 unless `QL_CFG_CRC_EN`)

## Operation
- Words per frame: NW = ceil(BL_WIDTH/DATA_W).
  - Word k of a frame lands in `bl[k*DATA_W +: DATA_W]`.
  - Bits of the last word above BL_WIDTH are discarded.
- Rows are written in order 0 … WL_ROWS-1. Frame n goes to `wl[n]`.
- States:
  - IDLE: all outputs at reset values.
    - `start` → LOAD; row=0, word=0, `bl` cleared.
  - LOAD: `cfg_ready`=1.
    - Each handshake (`cfg_valid & cfg_ready`) stores a word and increments `word`.
    - After the NW-th accepted word → WRITE.
  - WRITE: `wl[row]`=1 for exactly WL_PULSE cycles → GAP.
  - GAP: one cycle with `wl`=0.
    - Then row++ and word=0.
    - If row was WL_ROWS-1 → CHECK (with CRC) or RELEASE (without CRC); else → LOAD.
  - RELEASE: count RST_DELAY cycles, then set `global_resetn`=1 → DONE.
  - DONE: `cfg_done`=1, `global_resetn`=1, `bl` and `wl` held at 0.
    - `start` → LOAD (reconfigure). `global_resetn` and `cfg_done` drop to 0 in that same transition.
  - CHECK / ERROR: see Configuration.
- `start` is ignored in LOAD, WRITE, GAP, CHECK and RELEASE.
- `bl` is stable throughout WRITE and GAP. `bl` is cleared to 0 on entry to LOAD.
- `cfg_busy` = 1 in every state except IDLE, DONE and ERROR.
- `rst` at any point, including mid-row, aborts immediately and returns all outputs to their reset values.

## Timing
- Reset values:
  - State IDLE.
  - `bl`=0, `wl`=0, `global_resetn`=0.
  - `cfg_ready`=0, `cfg_busy`=0, `cfg_done`=0, `cfg_error`=0.
- `start` at cycle t → `cfg_ready`=1 and `cfg_busy`=1 at t+1.
- `cfg_ready` is a registered state decode. It does not depend on `cfg_valid`.
- Last word of a frame accepted at cycle t:
  - `cfg_ready`=0 from t+1.
  - `wl[row]` high during t+1 … t+WL_PULSE.
  - GAP at t+WL_PULSE+1.
  - Next LOAD at t+WL_PULSE+2.
- With `cfg_valid` held high, the cost per row is NW + WL_PULSE + 1 cycles.
- Stalls in `cfg_valid` extend LOAD indefinitely. There is no timeout.
- After the final GAP, `global_resetn` rises RST_DELAY cycles later. `cfg_done` rises in the same cycle.
- Counter widths: `row` is $clog2(WL_ROWS+1); `word` and the delay counter are sized to their maxima.

## Configuration
- Macro: `QL_CFG_CRC_EN`.
- Defined:
  - A CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, MSB-first, no final XOR, DATA_W must be 32) runs over every accepted frame word.
  - After the last GAP the FSM enters CHECK. It accepts exactly one trailer word, which is not included in the CRC.
  - Trailer equals the CRC → RELEASE.
  - Trailer differs → ERROR: `cfg_error`=1, `global_resetn` held at 0, `cfg_busy`=0.
  - ERROR is left only by `start` (→ LOAD, `cfg_error` cleared) or by `rst`.
- Undefined: no CHECK state, no trailer word, `cfg_error` tied to 0, no CRC logic.

## Structure
- `ql_cfg_pkg` contains:
  - the state enum `ql_cfg_state_e`;
  - `QL_CFG_CRC_POLY` and `QL_CFG_CRC_INIT`;
  - a function `ql_cfg_words(bl_width, data_w)` that returns NW.
- Sub-module `ql_cfg_crc32`: one-word-per-cycle combinational-update CRC register with `clear` and `en` inputs. Instantiated only under `QL_CFG_CRC_EN`.

## Test plan
Bench parameters: BL_WIDTH=40, WL_ROWS=3, DATA_W=32, WL_PULSE=2, RST_DELAY=4.

1. Reset: `rst` high for 3 cycles → every output at its reset value; `start` during `rst` ignored.
2. Clean load: `start`, then 6 words streamed back-to-back (row0 = 0xA5A5A5A5, 0x000000FF; row1 and row2 follow the same pattern).
   - `bl` = 40'hFF_A5A5A5A5 while `wl` = 3'b001 for 2 cycles; likewise for rows 1 and 2.
   - `global_resetn` and `cfg_done` rise 4 cycles after the final GAP.
3. Backpressure: drop `cfg_valid` for 5 cycles mid-frame → no WL pulse until the second word arrives; `bl` contents are unchanged.
4. Reset mid-operation: assert `rst` while `wl[1]`=1 → next cycle `wl`=0, `bl`=0, state IDLE; a new `start` reloads from row 0.
5. Reconfigure from DONE: `start` → `global_resetn`=0 and `cfg_done`=0 the next cycle; then a full load completes again.
6. CRC (with `QL_CFG_CRC_EN`):
   - Correct trailer → DONE.
   - Trailer XOR 1 → `cfg_error`=1, `global_resetn` stays 0, `cfg_busy`=0.
   - A subsequent `start` clears `cfg_error`.

Source files
------------

// File: rtl/ql_cfg_pkg.sv
// ---------------------------------------------------------------------------
// ql_cfg_pkg
// Shared definitions for the QL memory-bank configuration controller:
//   - ql_cfg_state_e : controller FSM state encoding (also exported for debug)
//   - QL_CFG_CRC_POLY / QL_CFG_CRC_INIT : CRC-32 constants for the optional
//     bitstream integrity check (enabled by QL_CFG_CRC_EN)
//   - ql_cfg_words() : number of stream words needed to fill one BL frame
// ---------------------------------------------------------------------------
package ql_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_WRITE   = 3'd2,
    ST_GAP     = 3'd3,
    ST_CHECK   = 3'd4,
    ST_RELEASE = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } ql_cfg_state_e;

  localparam logic [31:0] QL_CFG_CRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] QL_CFG_CRC_INIT = 32'hFFFF_FFFF;

  // Words per frame: ceil(bl_width / data_w).
  function automatic int ql_cfg_words(input int bl_width, input int data_w);
    return (bl_width + data_w - 1) / data_w;
  endfunction

endpackage

// File: rtl/ql_cfg_crc32.sv
// ---------------------------------------------------------------------------
// ql_cfg_crc32
// CRC-32 register that folds one 32-bit word per cycle (MSB-first,
// poly 0x04C11DB7, init 0xFFFFFFFF, no final XOR).
// Ports:
//   clk_i    : clock
//   rst_i    : synchronous active-high reset (loads the init value)
//   clear_i  : reload the init value (takes priority over en_i)
//   en_i     : fold data_i into the running CRC this cycle
//   data_i   : 32-bit word to fold
//   crc_o    : current CRC value (registered)
// ---------------------------------------------------------------------------
module ql_cfg_crc32
  import ql_cfg_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic [31:0] data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  function automatic logic [31:0] crc_step(input logic [31:0] c_in,
                                           input logic [31:0] d);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int i = 31; i >= 0; i--) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ QL_CFG_CRC_POLY;
    end
    return c;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (clear_i)   crc_d = QL_CFG_CRC_INIT;
    else if (en_i) crc_d = crc_step(crc_q, data_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) crc_q <= QL_CFG_CRC_INIT;
    else       crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/ql_membank_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// ql_membank_cfg_ctrl
// Configuration controller for the QL memory-bank fabric. Assembles one BL
// frame per word line from a valid/ready word stream, pulses the matching WL
// row, and releases global_resetn once every row has been written.
//
// Optional feature macro: QL_CFG_CRC_EN
//   Defined   : CRC-32 over all frame words, one trailer word checked after
//               the last row (CHECK state); mismatch parks in ERROR.
//   Undefined : no CRC logic, no trailer, cfg_error tied to 0.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : single-cycle request to (re)start configuration
//   cfg_data/valid    : bitstream word stream in
//   cfg_ready         : controller accepts the word this cycle
//   bl, wl            : fabric bit lines / word lines (wl one-hot or zero)
//   global_resetn     : fabric reset, high only when configured
//   cfg_busy/done/err : status
//   dbg_state         : current FSM state for observation
//
// Handshake: a word transfers on every rising edge where cfg_valid and
// cfg_ready are both 1. cfg_ready is a pure decode of the registered state
// (LOAD or CHECK) and never looks at cfg_valid; the source may hold
// cfg_valid low for any number of cycles, and must hold cfg_data stable
// while cfg_valid is high and the word has not yet been taken.
// ---------------------------------------------------------------------------
module ql_membank_cfg_ctrl
  import ql_cfg_pkg::*;
#(
  parameter int BL_WIDTH  = 514,
  parameter int WL_ROWS   = 407,
  parameter int DATA_W    = 32,
  parameter int WL_PULSE  = 2,
  parameter int RST_DELAY = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   cfg_data,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [BL_WIDTH-1:0] bl,
  output logic [WL_ROWS-1:0]  wl,
  output logic                global_resetn,
  output logic                cfg_busy,
  output logic                cfg_done,
  output logic                cfg_error,
  output ql_cfg_state_e       dbg_state
);

  localparam int NW     = ql_cfg_words(BL_WIDTH, DATA_W);
  localparam int WORD_W = $clog2(NW + 1);
  localparam int ROW_W  = $clog2(WL_ROWS + 1);
  localparam int PUL_W  = $clog2(WL_PULSE + 1);
  localparam int DLY_W  = $clog2(RST_DELAY + 1);

  ql_cfg_state_e       state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [PUL_W-1:0]    pul_q, pul_d;
  logic [DLY_W-1:0]    dly_q, dly_d;
  logic [BL_WIDTH-1:0] bl_q, bl_d;
  logic                hs;

`ifdef QL_CFG_CRC_EN
  logic        crc_clear;
  logic        crc_en;
  logic [31:0] crc_val;

  ql_cfg_crc32 u_crc (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (crc_clear),
    .en_i    (crc_en),
    .data_i  (cfg_data),
    .crc_o   (crc_val)
  );
`endif

  assign cfg_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign hs        = cfg_valid && cfg_ready;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    word_d  = word_q;
    pul_d   = pul_q;
    dly_d   = dly_q;
    bl_d    = bl_q;
`ifdef QL_CFG_CRC_EN
    crc_clear = 1'b0;
    crc_en    = 1'b0;
`endif
    case (state_q)
      // ERROR is only reachable with the CRC check built in.
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_LOAD;
          row_d   = '0;
          word_d  = '0;
          bl_d    = '0;
`ifdef QL_CFG_CRC_EN
          crc_clear = 1'b1;
`endif
        end
      end
      ST_LOAD: begin
        if (hs) begin
          // Scatter the word into its slot; bits beyond BL_WIDTH in the
          // last word simply have no destination.
          for (int i = 0; i < BL_WIDTH; i++) begin
            if (word_q == WORD_W'(i / DATA_W)) bl_d[i] = cfg_data[i % DATA_W];
          end
          word_d = word_q + 1'b1;
`ifdef QL_CFG_CRC_EN
          crc_en = 1'b1;
`endif
          if (word_q == WORD_W'(NW - 1)) begin
            state_d = ST_WRITE;
            pul_d   = '0;
          end
        end
      end
      ST_WRITE: begin
        if (pul_q == PUL_W'(WL_PULSE - 1)) state_d = ST_GAP;
        else                               pul_d   = pul_q + 1'b1;
      end
      ST_GAP: begin
        row_d  = row_q + 1'b1;
        word_d = '0;
        bl_d   = '0;
        if (row_q == ROW_W'(WL_ROWS - 1)) begin
`ifdef QL_CFG_CRC_EN
          state_d = ST_CHECK;
`else
          // The GAP cycle counts as the first delay cycle, so resetn rises
          // exactly RST_DELAY cycles after it.
          if (RST_DELAY == 1) state_d = ST_DONE;
          else begin
            state_d = ST_RELEASE;
            dly_d   = DLY_W'(1);
          end
`endif
        end else begin
          state_d = ST_LOAD;
        end
      end
`ifdef QL_CFG_CRC_EN
      ST_CHECK: begin
        if (hs) begin
          if (cfg_data == crc_val) begin
            if (RST_DELAY == 1) state_d = ST_DONE;
            else begin
              state_d = ST_RELEASE;
              dly_d   = DLY_W'(1);
            end
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
`endif
      ST_RELEASE: begin
        if (dly_q == DLY_W'(RST_DELAY - 1)) state_d = ST_DONE;
        else                                dly_d   = dly_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      word_q  <= '0;
      pul_q   <= '0;
      dly_q   <= '0;
      bl_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      word_q  <= word_d;
      pul_q   <= pul_d;
      dly_q   <= dly_d;
      bl_q    <= bl_d;
    end
  end

  // One-hot row decode, only while the pulse is active.
  always_comb begin
    wl = '0;
    if (state_q == ST_WRITE) begin
      for (int r = 0; r < WL_ROWS; r++) wl[r] = (row_q == ROW_W'(r));
    end
  end

  assign bl            = bl_q;
  assign global_resetn = (state_q == ST_DONE);
  assign cfg_done      = (state_q == ST_DONE);
  assign cfg_busy      = !((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                           (state_q == ST_ERROR));
`ifdef QL_CFG_CRC_EN
  assign cfg_error     = (state_q == ST_ERROR);
`else
  assign cfg_error     = 1'b0;
`endif
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ql_membank_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ql_membank_cfg_ctrl
// Self-checking bench for ql_membank_cfg_ctrl (BL_WIDTH=40, WL_ROWS=3,
// DATA_W=32, WL_PULSE=2, RST_DELAY=4). Expected frames are queued as they
// are driven and compared when the matching WL pulse appears. CRC scenarios
// run when QL_CFG_CRC_EN is defined.
// ---------------------------------------------------------------------------
module tb_ql_membank_cfg_ctrl;
  import ql_cfg_pkg::*;

  localparam int BLW   = 40;
  localparam int ROWS  = 3;
  localparam int DW    = 32;
  localparam int PULSE = 2;
  localparam int DLY   = 4;

  logic            clk;
  logic            rst;
  logic            start;
  logic [DW-1:0]   cfg_data;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [BLW-1:0]  bl;
  logic [ROWS-1:0] wl;
  logic            global_resetn;
  logic            cfg_busy;
  logic            cfg_done;
  logic            cfg_error;
  ql_cfg_state_e   dbg_state;

  ql_membank_cfg_ctrl #(
    .BL_WIDTH (BLW),
    .WL_ROWS  (ROWS),
    .DATA_W   (DW),
    .WL_PULSE (PULSE),
    .RST_DELAY(DLY)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .bl            (bl),
    .wl            (wl),
    .global_resetn (global_resetn),
    .cfg_busy      (cfg_busy),
    .cfg_done      (cfg_done),
    .cfg_error     (cfg_error),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Entry = {expected one-hot wl, expected bl frame}.
  logic [ROWS+BLW-1:0] exp_q[$];
  logic [ROWS+BLW-1:0] cur;
  bit                  in_pulse = 0;
  int                  len = 0;

  always @(negedge clk) begin
    if (wl != '0 && !in_pulse) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wl", 64'(wl), 64'(0));
      end else begin
        cur = exp_q.pop_front();
        check("wl_row", 64'(wl), 64'(cur[BLW +: ROWS]));
        check("bl_frame", 64'(bl), 64'(cur[BLW-1:0]));
      end
      in_pulse = 1;
      len      = 1;
    end else if (wl != '0) begin
      len++;
      check("wl_hold", 64'(wl), 64'(cur[BLW +: ROWS]));
      check("bl_stable", 64'(bl), 64'(cur[BLW-1:0]));
    end else if (in_pulse) begin
      check("wl_len", 64'(len), 64'(PULSE));
      check("bl_gap", 64'(bl), 64'(cur[BLW-1:0]));
      in_pulse = 0;
    end
    if (rst) begin
      in_pulse = 0;
      len      = 0;
    end
  end

  // ---------------- CRC model ----------------
  logic [31:0] crc_m;

  function automatic logic [31:0] crc_model(input logic [31:0] c_in,
                                            input logic [31:0] d);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int i = 31; i >= 0; i--) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ 32'h04C1_1DB7;
    end
    return c;
  endfunction

  // ---------------- drivers ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_word(input logic [31:0] d);
    int n;
    n         = 0;
    cfg_data  = d;
    cfg_valid = 1'b1;
    @(negedge clk);
    while (!cfg_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) check("ready_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic push_frame(input int row, input logic [31:0] w0,
                            input logic [31:0] w1);
    logic [ROWS-1:0] oh;
    oh = ROWS'(1) << row;
    exp_q.push_back({oh, w1[7:0], w0});
    crc_m = crc_model(crc_model(crc_m, w0), w1);
  endtask

  task automatic wait_done(input int exp_lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!global_resetn && n < 60);
    check("done_latency", 64'(n), 64'(exp_lat));
    check("done_flag", 64'(cfg_done), 64'(1));
    check("done_busy", 64'(cfg_busy), 64'(0));
    check("done_bl", 64'(bl), 64'(0));
    check("done_ready", 64'(cfg_ready), 64'(0));
    @(posedge clk);
    #1;
  endtask

  // Full configuration pass. mode 0: fixed pattern, 1: random words.
  task automatic run_config(input int mode, input bit bp, input bit bad_trailer);
    logic [31:0] w0, w1;
    do_start();
    @(negedge clk);
    check("start_ready", 64'(cfg_ready), 64'(1));
    check("start_busy", 64'(cfg_busy), 64'(1));
    check("start_resetn", 64'(global_resetn), 64'(0));
    check("start_done", 64'(cfg_done), 64'(0));
    check("start_bl", 64'(bl), 64'(0));
    @(posedge clk);
    #1;
    crc_m = 32'hFFFF_FFFF;
    for (int r = 0; r < ROWS; r++) begin
      if (mode == 0) begin
        w0 = 32'hA5A5_A5A5 ^ 32'(r);
        w1 = 32'h0000_00FF ^ {8'(r * 8'h11), 24'h0};
      end else begin
        w0 = $urandom;
        w1 = $urandom;
      end
      push_frame(r, w0, w1);
      send_word(w0);
      if (bp && r == 0) begin
        cfg_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
          start = (k == 2);
          @(negedge clk);
          check("bp_wl", 64'(wl), 64'(0));
          check("bp_bl", 64'(bl), {32'h0, w0});
          check("bp_state", 64'(dbg_state), 64'(ST_LOAD));
          @(posedge clk);
          #1;
          start = 1'b0;
        end
      end
      send_word(w1);
    end
`ifdef QL_CFG_CRC_EN
    send_word(crc_m ^ 32'(bad_trailer));
    if (bad_trailer) begin
      @(negedge clk);
      check("crc_err", 64'(cfg_error), 64'(1));
      check("crc_err_resetn", 64'(global_resetn), 64'(0));
      check("crc_err_busy", 64'(cfg_busy), 64'(0));
      @(posedge clk);
      #1;
    end else begin
      wait_done(DLY);
      check("crc_ok_err", 64'(cfg_error), 64'(0));
    end
`else
    check("no_crc_trailer_flag", 64'(bad_trailer), 64'(0));
    wait_done(PULSE + 1 + DLY);
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst       = 1'b1;
    start     = 1'b1;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_bl", 64'(bl), 64'(0));
    check("rst_wl", 64'(wl), 64'(0));
    check("rst_resetn", 64'(global_resetn), 64'(0));
    check("rst_ready", 64'(cfg_ready), 64'(0));
    check("rst_busy", 64'(cfg_busy), 64'(0));
    check("rst_done", 64'(cfg_done), 64'(0));
    check("rst_error", 64'(cfg_error), 64'(0));
    @(posedge clk);
    #1;

    // Clean load, then backpressure + reconfigure from DONE.
    run_config(0, 1'b0, 1'b0);
    run_config(1, 1'b1, 1'b0);

    // Reset while row 1 is being pulsed.
    do_start();
    @(posedge clk);
    #1;
    crc_m = 32'hFFFF_FFFF;
    push_frame(0, 32'h1234_5678, 32'h0000_009A);
    send_word(32'h1234_5678);
    send_word(32'h0000_009A);
    push_frame(1, 32'hCAFE_F00D, 32'h0000_0042);
    send_word(32'hCAFE_F00D);
    send_word(32'h0000_0042);
    rst = 1'b1;
    @(negedge clk);
    check("mid_wl1", 64'(wl), 64'(3'b010));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_wl", 64'(wl), 64'(0));
    check("mid_rst_bl", 64'(bl), 64'(0));
    check("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("mid_rst_busy", 64'(cfg_busy), 64'(0));
    @(posedge clk);
    #1;
    run_config(1, 1'b0, 1'b0);

`ifdef QL_CFG_CRC_EN
    run_config(1, 1'b0, 1'b1);
    do_start();
    @(negedge clk);
    check("err_cleared", 64'(cfg_error), 64'(0));
    check("err_restart_ready", 64'(cfg_ready), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
`endif

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
